// File: rtl/system_pkg.sv
// Shared SoC bus constants and types for the AHB-Lite data master.
package system_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef struct packed {
    logic       legal;
    logic [2:0] hsize;
    logic [1:0] addr_lo;
  } be_decode_t;

endpackage

// File: rtl/obi_be_decode.sv
// Byte-enable to HSIZE / HADDR[1:0] decoder; any non-naturally-aligned pattern is illegal.
module obi_be_decode
  import system_pkg::*;
(
  input  logic [3:0] be,
  output be_decode_t dec
);

  always_comb begin
    dec = '{legal: 1'b1, hsize: HSIZE_BYTE, addr_lo: 2'd0};
    case (be)
      4'b0001: dec.addr_lo = 2'd0;
      4'b0010: dec.addr_lo = 2'd1;
      4'b0100: dec.addr_lo = 2'd2;
      4'b1000: dec.addr_lo = 2'd3;
      4'b0011: dec.hsize   = HSIZE_HALF;
      4'b1100: begin
        dec.hsize   = HSIZE_HALF;
        dec.addr_lo = 2'd2;
      end
      4'b1111: dec.hsize   = HSIZE_WORD;
      default: dec.legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahbl_data_master.sv
// OBI-style data request to single AHB-Lite transfers, one outstanding data phase.
module ahbl_data_master
  import system_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = system_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = system_pkg::DATA_WIDTH,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic [ADDR_WIDTH-1:0] ahbl_haddr,
  output logic [2:0]            ahbl_hburst,
  output logic                  ahbl_hmastlock,
  output logic [3:0]            ahbl_hprot,
  output logic [2:0]            ahbl_hsize,
  output logic [1:0]            ahbl_htrans,
  output logic [DATA_WIDTH-1:0] ahbl_hwdata,
  output logic                  ahbl_hwrite,
  input  logic [DATA_WIDTH-1:0] ahbl_hrdata,
  input  logic                  ahbl_hready,
  input  logic                  ahbl_hresp
);

  be_decode_t            be_dec;
  logic                  dp_valid_q, dp_we_q, ill_pend_q;
  logic [DATA_WIDTH-1:0] dp_wdata_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [2:0]            hsize_q;
  logic                  hwrite_q;
  logic                  err_first, dp_done, req_ok, issue, bus_gnt, ill_gnt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  unused_addr_lo;

  assign unused_addr_lo = ^data_addr_i[1:0];

  obi_be_decode u_be_decode (
    .be  (data_be_i),
    .dec (be_dec)
  );

  always_comb begin
    err_first = dp_valid_q & ahbl_hresp & ~ahbl_hready;
    dp_done   = dp_valid_q & ahbl_hready;
    // Nothing may be granted in the first ERROR cycle or while an illegal-be response is owed.
    req_ok    = data_req_i & ~rst & ~err_first & ~ill_pend_q;
    issue     = req_ok & be_dec.legal;
    bus_gnt   = issue & ahbl_hready;
    ill_gnt   = req_ok & ~be_dec.legal & (~dp_valid_q | ahbl_hready);
    req_addr  = {data_addr_i[ADDR_WIDTH-1:2], be_dec.addr_lo};
  end

  always_comb begin
    ahbl_htrans   = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    ahbl_haddr    = issue ? req_addr : haddr_q;
    ahbl_hsize    = issue ? be_dec.hsize : hsize_q;
    ahbl_hwrite   = issue ? data_we_i : hwrite_q;
    ahbl_hwdata   = dp_wdata_q;
    data_gnt_o    = bus_gnt | ill_gnt;
    data_rvalid_o = dp_done | ill_pend_q;
    data_err_o    = ill_pend_q | (dp_done & ahbl_hresp);
    data_rdata_o  = (dp_done & ~dp_we_q) ? ahbl_hrdata : '0;
  end

  assign ahbl_hburst    = HBURST_SINGLE;
  assign ahbl_hmastlock = 1'b0;
  assign ahbl_hprot     = HPROT_VAL;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid_q <= 1'b0;
      dp_we_q    <= 1'b0;
      dp_wdata_q <= '0;
      ill_pend_q <= 1'b0;
      haddr_q    <= '0;
      hsize_q    <= HSIZE_BYTE;
      hwrite_q   <= 1'b0;
    end else begin
      if (bus_gnt) begin
        dp_valid_q <= 1'b1;
        dp_we_q    <= data_we_i;
        dp_wdata_q <= data_wdata_i;
      end else if (ahbl_hready) begin
        dp_valid_q <= 1'b0;
      end
      ill_pend_q <= ill_gnt;
      if (issue) begin
        haddr_q  <= req_addr;
        hsize_q  <= be_dec.hsize;
        hwrite_q <= data_we_i;
      end
    end
  end

endmodule

// File: doc/ahbl_data_master.md
Name: ahbl_data_master

Overview:
- AHB-Lite initiator that turns the core's OBI-style data request interface (req/gnt/rvalid) into single AHB-Lite transfers.
- Feeds the SoC AHB-Lite fabric and the on-chip SRAM slaves.
- Pipelines address and data phases (one outstanding data phase), converts byte-enables to HSIZE/HADDR[1:0], and handles wait states and the two-cycle ERROR response.

Parameters:
- ADDR_WIDTH, 32 (system_pkg::ADDR_WIDTH): address width.
- DATA_WIDTH, 32 (system_pkg::DATA_WIDTH): data width; only 32 is supported.
- HPROT_VAL, 4'b0011: constant HPROT, data access, privileged, non-bufferable, non-cacheable.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- data_req_i  input  1  core request; held stable until granted.
- data_we_i  input  1  1 = store.
- data_be_i  input  4  byte enables.
- data_addr_i  input  ADDR_WIDTH  word-aligned address; bits [1:0] are ignored.
- data_wdata_i  input  DATA_WIDTH  store data, already lane-aligned.
- data_gnt_o  output  1  request accepted this cycle.
- data_rvalid_o  output  1  response valid, one cycle per grant.
- data_rdata_o  output  DATA_WIDTH  load data, full word.
- data_err_o  output  1  response is an error; qualified by rvalid.
- ahbl_haddr  output  ADDR_WIDTH
- ahbl_hburst  output  3  constant SINGLE (3'b000).
- ahbl_hmastlock  output  1  constant 0.
- ahbl_hprot  output  4  constant HPROT_VAL.
- ahbl_hsize  output  3
- ahbl_htrans  output  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- ahbl_hwdata  output  DATA_WIDTH
- ahbl_hwrite  output  1
- ahbl_hrdata  input  DATA_WIDTH
- ahbl_hready  input  1
- ahbl_hresp  input  1

Behaviour:
- Reset (rst=1 at a clk edge):
  - next cycle: dp_valid=0, ill_pend=0, all data_* outputs 0, htrans IDLE, haddr/hwdata/hsize/hwrite 0.
  - reset mid-transfer abandons the data phase; no rvalid is produced.
- Byte-enable decode:
  - 0001/0010/0100/1000 → hsize BYTE, haddr[1:0] = 0/1/2/3.
  - 0011 → HALF, haddr[1:0]=0; 1100 → HALF, haddr[1:0]=2.
  - 1111 → WORD, haddr[1:0]=0.
  - any other be (including 0000) is illegal.
- Address phase (combinational from request):
  - issue = data_req_i & legal & ~err_first & ~ill_pend.
  - While issue: htrans=NONSEQ; haddr, hsize and hwrite are driven from the request.
  - Otherwise htrans=IDLE and haddr/hsize/hwrite hold their last issued values.
  - data_gnt_o = issue & ahbl_hready. A stalled address phase stays unchanged until HREADY.
- Data phase registers:
  - On gnt, load dp_valid=1, dp_we and dp_wdata.
  - On HREADY with no new gnt, clear dp_valid.
  - ahbl_hwdata = dp_wdata throughout the data phase, held during wait states.
- Response:
  - When dp_valid & ahbl_hready: rvalid=1 same cycle, rdata=ahbl_hrdata (0 for stores), err=ahbl_hresp.
  - Back-to-back: a gnt in the same cycle as a response is allowed (full pipelining, 1 transfer/cycle at zero wait).
- ERROR response:
  - err_first = dp_valid & hresp & ~hready forces htrans=IDLE and gnt=0, as required by AHB-Lite.
  - The following hresp=1/hready=1 cycle gives rvalid=1, err=1.
- Illegal be:
  - Granted (gnt=1, no bus transfer, htrans IDLE) only when dp_valid=0 or the data phase completes that cycle; sets ill_pend.
  - Next cycle: rvalid=1, err=1, rdata=0; ill_pend clears. No new grant in that cycle.
- Ordering: responses are always returned in grant order; at most one response per cycle.

Decomposition:
- system_pkg additions:
  - HTRANS_IDLE/NONSEQ constants.
  - HSIZE_BYTE/HALF/WORD constants.
  - HBURST_SINGLE constant.
  - a be_decode_t struct {legal, hsize, addr_lo}.
- One sub-module, obi_be_decode: combinational be → be_decode_t.
- Top level holds the data-phase and ill_pend registers plus the handshake logic.

Test Plan:
- Load word at 0x100, be=1111, HREADY=1 → cycle0 gnt=1, htrans=NONSEQ, hsize=010, haddr=0x100; cycle1 rvalid=1, rdata=hrdata=0xDEADBEEF, err=0.
- Store byte to 0x203, be=1000, wdata=0xAB000000 → haddr=0x203, hsize=000, hwrite=1; hwdata=0xAB000000 next cycle; rvalid the cycle after the address phase.
- Two back-to-back loads, slave inserts 2 wait states on the first data phase → second address phase held with gnt=0 for 2 cycles; rvalid pulses in order; no lost or duplicated transfer.
- ERROR response: hresp=1/hready=0 then hresp=1/hready=1 with a pending req → htrans=IDLE and gnt=0 in the first cycle; rvalid=1, err=1 in the second; pending req granted afterwards.
- Illegal be=0101 → gnt=1 with htrans=IDLE; next cycle rvalid=1, err=1, rdata=0; no HTRANS=NONSEQ observed.
- rst=1 asserted during a wait-stated data phase → next cycle htrans=IDLE, rvalid=0, gnt=0; a fresh load after reset completes normally.
